timer_alarm: RTL and testbench
==============================

Name: timer_alarm

Overview:
- Programmable down-counting alarm: the event-generating counterpart of the free-running up-counting wrap timer.
- Software loads a 64-bit interval as two DATA_W halves, selects one-shot or periodic mode and starts it.
- Block raises a one-cycle pulse plus a sticky interrupt on expiry.
- Sits beside the timer on the same register-bank interface; the remaining count can be sampled the same way the timer count is sampled.

Parameters:
- DATA_W, 32, width of each software register half.
- TIMER_W, 64, counter width; must equal 2*DATA_W.
- PRESC_W, 16, prescaler width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- ALARM_EN  in  1  count enable; low freezes prescaler and counter (pause).
- ALARM_MODE  in  1  0 = one-shot, 1 = periodic.
- LOAD_H  in  DATA_W  interval upper half.
- LOAD_L  in  DATA_W  interval lower half; L = {LOAD_H,LOAD_L}.
- PRESC  in  PRESC_W  tick every PRESC+1 enabled clocks.
- ALARM_START  in  1  single-cycle start/restart strobe.
- ALARM_STOP  in  1  single-cycle stop strobe.
- IRQ_CLR  in  1  single-cycle clear of ALARM_IRQ and ALARM_OVR.
- ALARM_S  in  1  sample strobe for ALARM_REMAIN.
- ALARM_REMAIN  out  TIMER_W  sampled remaining count.
- ALARM_IRQ  out  1  sticky expiry flag.
- ALARM_PULSE  out  1  one-cycle expiry pulse.
- ALARM_BUSY  out  1  high while state is RUN.
- ALARM_OVR  out  1  sticky flag: expiry occurred while ALARM_IRQ was already set.

Behaviour:
- Reset (synchronous, rst=1 at an edge):
  - state=IDLE; count, presc_cnt and ALARM_REMAIN = 0.
  - ALARM_IRQ, ALARM_PULSE, ALARM_BUSY, ALARM_OVR = 0.
  - Applies identically mid-operation; no expiry is generated on the reset edge.
- States:
  - IDLE: not counting.
  - RUN: counting.
  - DONE: one-shot expired; holds count=0.
- START, sampled in any state: count<=L, presc_cnt<=0, state<=RUN. A START while in RUN restarts with a fresh L.
- STOP: state<=IDLE; count holds its value; IRQ/OVR unchanged. STOP and START in the same cycle: STOP wins.
- Tick: in RUN with ALARM_EN=1 and presc_cnt>=PRESC, set presc_cnt<=0 and tick. Otherwise, in RUN with EN=1, presc_cnt<=presc_cnt+1. The >= compare keeps a live PRESC decrease from wrapping.
- On tick:
  - count!=0: count<=count-1.
  - count==0: expiry.
- Expiry:
  - ALARM_PULSE<=1 for exactly one cycle.
  - ALARM_IRQ<=1.
  - If ALARM_IRQ was already 1, ALARM_OVR<=1.
  - One-shot: state<=DONE.
  - Periodic: count<=current L (LOAD changes during RUN take effect at the next reload) and stay in RUN.
- Latency: START sampled at edge k gives expiry at edge k+(L+1)*(PRESC+1), with EN held high. L=0 expires on the first tick.
- IRQ_CLR: clears IRQ and OVR. If an expiry happens in the same cycle, set wins: IRQ=1 and OVR=0. OVR is not set by that expiry because the clear is accounted first.
- ALARM_S: ALARM_REMAIN<=count at that edge; it otherwise holds. A sample coinciding with a decrement captures the pre-decrement value.
- ALARM_BUSY: registered, equals (state==RUN).
- Width rule: all count arithmetic is TIMER_W unsigned; no wrap below 0 because 0 triggers expiry instead of a decrement.
- ALARM_MODE is read only at expiry; changing it mid-run affects only the current period's end behaviour.

Test Plan:
- L=3, PRESC=0, one-shot, EN=1, START at edge k -> PULSE high exactly after edge k+4 for 1 cycle; IRQ=1; BUSY=0; state DONE, REMAIN sample =0.
- L=1, PRESC=2, periodic, run 20 cycles -> PULSE every 6 cycles (edges k+6, k+12, k+18); OVR=1 after the second pulse without IRQ_CLR.
- L=5, PRESC=0, drop EN for 4 cycles after edge k+2 -> expiry delayed to edge k+10; ALARM_S during the pause returns 3.
- L=0 with PRESC=0 -> expiry at edge k+1. Separately: START and STOP in the same cycle -> IDLE, BUSY=0, no pulse.
- IRQ_CLR coincident with a periodic expiry -> IRQ=1, OVR=0.
- rst asserted mid-RUN with count=7 -> after that edge all outputs 0, state IDLE, no pulse on following cycles.
- Restart START at count=2 with L=9 -> expiry 10 ticks later.

Source files
------------

// File: rtl/timer_alarm.sv
// Programmable down-counting alarm with prescaler, one-shot/periodic modes,
// expiry pulse, sticky IRQ/overrun flags and a sampled remaining-count view.
//
// state | meaning
// IDLE  | not counting; count holds its last value
// RUN   | counting down on prescaler ticks
// DONE  | one-shot expired; count held at zero
module timer_alarm #(
  parameter int DATA_W  = 32,
  parameter int TIMER_W = 64,
  parameter int PRESC_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ALARM_EN,
  input  logic               ALARM_MODE,
  input  logic [DATA_W-1:0]  LOAD_H,
  input  logic [DATA_W-1:0]  LOAD_L,
  input  logic [PRESC_W-1:0] PRESC,
  input  logic               ALARM_START,
  input  logic               ALARM_STOP,
  input  logic               IRQ_CLR,
  input  logic               ALARM_S,
  output logic [TIMER_W-1:0] ALARM_REMAIN,
  output logic               ALARM_IRQ,
  output logic               ALARM_PULSE,
  output logic               ALARM_BUSY,
  output logic               ALARM_OVR
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  logic [TIMER_W-1:0]   count;
  logic [PRESC_W-1:0]   presc_cnt;
  logic [TIMER_W-1:0]   load;
  logic                 counting;
  logic                 tick;
  logic                 expire;

  assign load = {LOAD_H, LOAD_L};

  // STOP and START both pre-empt counting in their cycle, so neither can
  // coincide with an expiry.
  always_comb begin
    counting = 1'b0;
    tick     = 1'b0;
    expire   = 1'b0;
    counting = (state == RUN) && ALARM_EN && !ALARM_STOP && !ALARM_START;
    tick     = counting && (presc_cnt >= PRESC);
    expire   = tick && (count == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      count        <= '0;
      presc_cnt    <= '0;
      ALARM_REMAIN <= '0;
      ALARM_IRQ    <= 1'b0;
      ALARM_PULSE  <= 1'b0;
      ALARM_BUSY   <= 1'b0;
      ALARM_OVR    <= 1'b0;
    end else begin
      if (ALARM_S) begin
        ALARM_REMAIN <= count;
      end

      if (ALARM_STOP) begin
        state      <= IDLE;
        ALARM_BUSY <= 1'b0;
      end else if (ALARM_START) begin
        count      <= load;
        presc_cnt  <= '0;
        state      <= RUN;
        ALARM_BUSY <= 1'b1;
      end else if (counting) begin
        if (tick) begin
          presc_cnt <= '0;
          if (count != '0) begin
            count <= count - TIMER_W'(1);
          end else if (ALARM_MODE) begin
            count <= load;
          end else begin
            state      <= DONE;
            ALARM_BUSY <= 1'b0;
          end
        end else begin
          presc_cnt <= presc_cnt + PRESC_W'(1);
        end
      end

      // Clear is accounted before the expiry, so set wins for IRQ while OVR
      // only latches when the flag survives the clear.
      ALARM_PULSE <= expire;
      ALARM_IRQ   <= (ALARM_IRQ & ~IRQ_CLR) | expire;
      ALARM_OVR   <= (ALARM_OVR & ~IRQ_CLR) | (expire & ALARM_IRQ & ~IRQ_CLR);
    end
  end

endmodule

// File: tb/tb_timer_alarm.sv
// Self-checking bench for timer_alarm: directed scenarios with hand-derived
// expectations plus a randomized run against an arithmetic reference model.
module tb_timer_alarm;

  localparam int DATA_W  = 32;
  localparam int TIMER_W = 64;
  localparam int PRESC_W = 16;

  logic               clk;
  logic               rst;
  logic               en;
  logic               mode;
  logic [DATA_W-1:0]  load_h;
  logic [DATA_W-1:0]  load_l;
  logic [PRESC_W-1:0] presc;
  logic               start;
  logic               stop;
  logic               irq_clr;
  logic               samp;
  logic [TIMER_W-1:0] remain;
  logic               irq;
  logic               pulse;
  logic               busy;
  logic               ovr;

  int n_checks = 0;
  int n_pass   = 0;

  timer_alarm #(.DATA_W(DATA_W), .TIMER_W(TIMER_W), .PRESC_W(PRESC_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .ALARM_EN     (en),
    .ALARM_MODE   (mode),
    .LOAD_H       (load_h),
    .LOAD_L       (load_l),
    .PRESC        (presc),
    .ALARM_START  (start),
    .ALARM_STOP   (stop),
    .IRQ_CLR      (irq_clr),
    .ALARM_S      (samp),
    .ALARM_REMAIN (remain),
    .ALARM_IRQ    (irq),
    .ALARM_PULSE  (pulse),
    .ALARM_BUSY   (busy),
    .ALARM_OVR    (ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: progress is tracked as enabled clocks since the start of
  // the current period; the count follows from L - e/(P+1).
  bit          m_run;
  longint      m_hold;
  longint      m_e;
  longint      m_l;
  longint      m_p;
  bit          m_irq, m_ovr, m_pulse;
  longint      m_remain;

  task automatic model_step();
    longint cur;
    bit     exp_now;
    cur     = m_run ? (m_l - m_e / (m_p + 1)) : m_hold;
    exp_now = 1'b0;
    if (rst) begin
      m_run = 0; m_hold = 0; m_e = 0; m_irq = 0; m_ovr = 0; m_pulse = 0; m_remain = 0;
      return;
    end
    if (samp) m_remain = cur;
    if (stop) begin
      m_hold = cur;
      m_run  = 0;
    end else if (start) begin
      m_run = 1;
      m_e   = 0;
      m_l   = longint'({load_h, load_l});
      m_p   = longint'(presc);
    end else if (m_run && en) begin
      m_e = m_e + 1;
      if (m_e == (m_l + 1) * (m_p + 1)) begin
        exp_now = 1'b1;
        m_e     = 0;
        if (!mode) begin
          m_run  = 0;
          m_hold = 0;
        end
      end
    end
    m_pulse = exp_now;
    m_ovr   = (m_ovr & ~irq_clr) | (exp_now & m_irq & ~irq_clr);
    m_irq   = (m_irq & ~irq_clr) | exp_now;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    start = 0; stop = 0; irq_clr = 0; samp = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    step();
    rst = 0;
  endtask

  task automatic arm(input logic [DATA_W-1:0] l, input logic [PRESC_W-1:0] p,
                     input logic md);
    load_h = '0; load_l = l; presc = p; mode = md; en = 1;
    start = 1;
    step();
    start = 0;
  endtask

  task automatic test_reset();
    rst = 1; en = 0; mode = 0; load_h = '0; load_l = '0; presc = '0;
    idle_inputs();
    step(); step();
    rst = 0;
    n_checks++;
    if ({remain, irq, pulse, busy, ovr} !== '0)
      $display("FAIL reset_outputs: got remain=%0h irq=%0b pulse=%0b busy=%0b ovr=%0b, want all 0",
               remain, irq, pulse, busy, ovr);
    else n_pass++;
  endtask

  task automatic test_oneshot();
    do_reset();
    arm(3, 0, 0);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL oneshot_busy_start: got %0b want 1", busy);
    else n_pass++;
    for (int j = 1; j <= 6; j++) begin
      step();
      n_checks++;
      if (pulse !== (j == 4)) $display("FAIL oneshot_pulse_k+%0d: got %0b want %0b", j, pulse, j == 4);
      else n_pass++;
      if (j == 4) begin
        n_checks++;
        if (irq !== 1'b1 || busy !== 1'b0)
          $display("FAIL oneshot_flags: got irq=%0b busy=%0b want irq=1 busy=0", irq, busy);
        else n_pass++;
      end
    end
    samp = 1; step(); samp = 0;
    n_checks++;
    if (remain !== 64'd0) $display("FAIL oneshot_remain: got %0d want 0", remain);
    else n_pass++;
  endtask

  task automatic test_periodic_ovr();
    do_reset();
    arm(1, 2, 1);
    for (int j = 1; j <= 20; j++) begin
      step();
      n_checks++;
      if (pulse !== (j % 6 == 0)) $display("FAIL periodic_pulse_k+%0d: got %0b want %0b", j, pulse, j % 6 == 0);
      else n_pass++;
      if (j == 6 || j == 12) begin
        n_checks++;
        if (ovr !== (j == 12)) $display("FAIL periodic_ovr_k+%0d: got %0b want %0b", j, ovr, j == 12);
        else n_pass++;
      end
    end
  endtask

  task automatic test_pause();
    do_reset();
    arm(5, 0, 0);
    step(); step();
    for (int j = 3; j <= 12; j++) begin
      en   = !(j >= 3 && j <= 6);
      samp = (j == 4);
      step();
      samp = 0;
      n_checks++;
      if (pulse !== (j == 10)) $display("FAIL pause_pulse_k+%0d: got %0b want %0b", j, pulse, j == 10);
      else n_pass++;
      if (j == 4) begin
        n_checks++;
        if (remain !== 64'd3) $display("FAIL pause_remain: got %0d want 3", remain);
        else n_pass++;
      end
    end
    en = 1;
  endtask

  task automatic test_zero_and_stopstart();
    do_reset();
    arm(0, 0, 0);
    step();
    n_checks++;
    if (pulse !== 1'b1 || busy !== 1'b0)
      $display("FAIL zero_expiry: got pulse=%0b busy=%0b want pulse=1 busy=0", pulse, busy);
    else n_pass++;
    arm(5, 0, 0);
    step();
    start = 1; stop = 1; step(); idle_inputs();
    n_checks++;
    if (busy !== 1'b0) $display("FAIL stopstart_busy: got %0b want 0", busy);
    else n_pass++;
    for (int j = 0; j < 8; j++) begin
      step();
      n_checks++;
      if (pulse !== 1'b0 || busy !== 1'b0)
        $display("FAIL stopstart_quiet_%0d: got pulse=%0b busy=%0b want 0 0", j, pulse, busy);
      else n_pass++;
    end
  endtask

  task automatic test_clr_coincident();
    do_reset();
    arm(1, 0, 1);
    step(); step();
    n_checks++;
    if (pulse !== 1'b1 || irq !== 1'b1) $display("FAIL clr_first_expiry: got pulse=%0b irq=%0b want 1 1", pulse, irq);
    else n_pass++;
    step();
    irq_clr = 1; step(); irq_clr = 0;
    n_checks++;
    if (pulse !== 1'b1 || irq !== 1'b1 || ovr !== 1'b0)
      $display("FAIL clr_coincident: got pulse=%0b irq=%0b ovr=%0b want 1 1 0", pulse, irq, ovr);
    else n_pass++;
  endtask

  task automatic test_reset_midrun();
    do_reset();
    arm(10, 0, 0);
    step(); step();
    samp = 1; step(); samp = 0;
    n_checks++;
    if (remain !== 64'd8) $display("FAIL midrun_presample: got %0d want 8", remain);
    else n_pass++;
    rst = 1; step(); rst = 0;
    n_checks++;
    if ({remain, irq, pulse, busy, ovr} !== '0)
      $display("FAIL midrun_reset: got remain=%0h irq=%0b pulse=%0b busy=%0b ovr=%0b want all 0",
               remain, irq, pulse, busy, ovr);
    else n_pass++;
    for (int j = 0; j < 12; j++) begin
      step();
      n_checks++;
      if (pulse !== 1'b0 || busy !== 1'b0)
        $display("FAIL midrun_after_%0d: got pulse=%0b busy=%0b want 0 0", j, pulse, busy);
      else n_pass++;
    end
  endtask

  task automatic test_restart();
    do_reset();
    arm(5, 0, 0);
    step(); step(); step();
    load_l = 9; start = 1; step(); start = 0;
    for (int j = 1; j <= 12; j++) begin
      step();
      n_checks++;
      if (pulse !== (j == 10)) $display("FAIL restart_pulse_k+%0d: got %0b want %0b", j, pulse, j == 10);
      else n_pass++;
    end
  endtask

  task automatic test_wide_borrow();
    do_reset();
    load_h = 32'h1; load_l = '0; presc = '0; mode = 0; en = 1;
    start = 1; step(); start = 0;
    samp = 1; step();
    n_checks++;
    if (remain !== 64'h1_0000_0000) $display("FAIL wide_load: got %0h want 100000000", remain);
    else n_pass++;
    step(); samp = 0;
    n_checks++;
    if (remain !== 64'h0_FFFF_FFFF) $display("FAIL wide_borrow: got %0h want ffffffff", remain);
    else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    load_h = '0; load_l = 3; presc = 1; mode = 1; en = 1;
    for (int c = 0; c < 1500; c++) begin
      idle_inputs();
      if ($urandom_range(15, 0) == 0) begin
        load_l = $urandom_range(7, 0);
        presc  = PRESC_W'($urandom_range(3, 0));
        start  = 1;
      end
      stop    = ($urandom_range(39, 0) == 0);
      en      = ($urandom_range(4, 0) != 0);
      mode    = $urandom_range(1, 0);
      samp    = ($urandom_range(3, 0) == 0);
      irq_clr = ($urandom_range(9, 0) == 0);
      rst     = ($urandom_range(299, 0) == 0);
      step();
      rst = 0;
      n_checks++;
      if (pulse !== m_pulse) $display("FAIL rnd_pulse c=%0d: got %0b want %0b", c, pulse, m_pulse);
      else n_pass++;
      n_checks++;
      if (irq !== m_irq) $display("FAIL rnd_irq c=%0d: got %0b want %0b", c, irq, m_irq);
      else n_pass++;
      n_checks++;
      if (ovr !== m_ovr) $display("FAIL rnd_ovr c=%0d: got %0b want %0b", c, ovr, m_ovr);
      else n_pass++;
      n_checks++;
      if (busy !== m_run) $display("FAIL rnd_busy c=%0d: got %0b want %0b", c, busy, m_run);
      else n_pass++;
      n_checks++;
      if (remain !== 64'(m_remain)) $display("FAIL rnd_remain c=%0d: got %0d want %0d", c, remain, m_remain);
      else n_pass++;
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_periodic_ovr();
    test_pause();
    test_zero_and_stopstart();
    test_clr_coincident();
    test_reset_midrun();
    test_restart();
    test_wide_borrow();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
